// File: rtl/alu_arbiter_if.sv
// One requester's channel into the ALU arbiter: an op request and its result return.
interface alu_arbiter_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_zero;
  logic             resp_neg;
  logic             resp_err;

  modport master (
    output valid, op, a, b, resp_ready,
    input  ready, resp_valid, resp_data, resp_zero, resp_neg, resp_err
  );

  modport slave (
    input  valid, op, a, b, resp_ready,
    output ready, resp_valid, resp_data, resp_zero, resp_neg, resp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU result path between two requesters.
// Legal op: accept, one issue cycle, then a response held until taken; illegal op answers directly.
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  alu_arbiter_if.slave      r0,
  alu_arbiter_if.slave      r1,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        alu_sel,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state;
  logic             grant;
  logic             last_grant;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             neg_q;
  logic             err_q;

  logic             any_valid;
  logic             pick;
  logic [2:0]       pick_op;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  logic             op_legal;
  logic             resp_take;

  // With both valid the one not served last wins; a lone requester always wins.
  always_comb begin
    any_valid = r0.valid | r1.valid;
    pick      = (r0.valid & r1.valid) ? ~last_grant : r1.valid;
    pick_op   = pick ? r1.op : r0.op;
    pick_a    = pick ? r1.a  : r0.a;
    pick_b    = pick ? r1.b  : r0.b;
    op_legal  = (pick_op != 3'b001) && (pick_op != 3'b111);
    resp_take = grant ? r1.resp_ready : r0.resp_ready;
  end

  assign r0.ready = (state == IDLE) & r0.valid & ~pick;
  assign r1.ready = (state == IDLE) & r1.valid &  pick;

  assign r0.resp_valid = (state == RESP) & ~grant;
  assign r1.resp_valid = (state == RESP) &  grant;
  assign r0.resp_data  = res_q;
  assign r1.resp_data  = res_q;
  assign r0.resp_zero  = zero_q;
  assign r1.resp_zero  = zero_q;
  assign r0.resp_neg   = neg_q;
  assign r1.resp_neg   = neg_q;
  assign r0.resp_err   = err_q;
  assign r1.resp_err   = err_q;

  assign busy = (state != IDLE);

  // The alu_* registers double as the operand latch, so they only move on a legal accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= 3'b000;
      res_q      <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant <= pick;
            if (op_legal) begin
              alu_a   <= pick_a;
              alu_b   <= pick_b;
              alu_sel <= pick_op;
              state   <= ISSUE;
            end else begin
              res_q  <= '0;
              zero_q <= 1'b1;
              neg_q  <= 1'b0;
              err_q  <= 1'b1;
              state  <= RESP;
            end
          end
        end
        ISSUE: begin
          res_q  <= alu_result;
          zero_q <= (alu_result == '0);
          neg_q  <= alu_result[WIDTH-1];
          err_q  <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (resp_take) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 64-bit ALU result path (adder/logic units feeding the 5-input result mux). It accepts operation requests from two clients over valid/ready handshakes, grants the ALU round-robin, and drives operands and the mux select. It registers the mux output and returns the result, zero and negative flags, and an illegal-op error to the granted client. It sits between the execute-stage control and the ALU/mux datapath.

## Interface
Parameters:
- WIDTH, 64, operand/result width

Ports (N ∈ {0,1}, one set per requester):
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- rN_valid  in  1  request N presents an operation
- rN_ready  out  1  1-cycle pulse: request N accepted this cycle
- rN_op  in  3  ALU control code
- rN_a, rN_b  in  WIDTH  operands
- rN_resp_valid  out  1  response N available; held until taken
- rN_resp_ready  in  1  client N takes response
- rN_resp_data  out  WIDTH  result
- rN_resp_zero  out  1  result == 0
- rN_resp_neg  out  1  result[WIDTH-1]
- rN_resp_err  out  1  op code was illegal
- alu_a, alu_b  out  WIDTH  operands to ALU
- alu_sel  out  3  select to result mux / ALU control
- alu_result  in  WIDTH  mux output (combinational from alu_a/alu_b/alu_sel)
- busy  out  1  FSM not in IDLE

## Operation
- Op codes: 000 pass B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR. 001 and 111 illegal.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any rN_valid, pick grantee via round-robin; assert its rN_ready for that cycle; latch op/a/b and grant id. Legal op -> ISSUE; illegal op -> RESP with err=1, data=0, zero=1, neg=0, ALU not driven.
- ISSUE (1 cycle): alu_a/alu_b/alu_sel driven from latched registers; at end of cycle register alu_result, zero, neg. -> RESP.
- RESP: grantee's rN_resp_valid=1 with registered data/flags; other requester's resp_valid=0. On rN_resp_ready=1 -> IDLE; update last_grant.
- Round-robin: last_grant register. Both valid -> grant the one not last granted. Only one valid -> grant it regardless. Reset value of last_grant = 1 (requester 0 wins first tie).
- Illegal-op responses also update last_grant.
- Requests are not accepted outside IDLE; rN_ready=0 in ISSUE/RESP. Clients hold valid/op/a/b until ready.
- Operands/op are sampled only on the accept cycle; later changes are ignored.
- alu_a, alu_b hold last issued values outside ISSUE; alu_sel holds last value (000 after reset).

## Timing
- Reset values: rN_ready=0, rN_resp_valid=0, rN_resp_data=0, flags=0, alu_a=alu_b=0, alu_sel=000, busy=0, state IDLE, last_grant=1.
- Reset mid-operation: in-flight op dropped, no response issued, all of the above restored next edge.
- Legal op: accept at cycle T (ready high in T), ISSUE in T+1, resp_valid high from T+2. If resp_ready=1 at T+2, next accept possible at T+3. Minimum 3 cycles/op.
- Illegal op: accept at T, resp_valid from T+1.
- resp_valid and resp_data stable while resp_ready=0 (backpressure unbounded).
- busy=1 in ISSUE and RESP.
- No combinational path from rN_valid to alu_* or from alu_result to any output; rN_ready is a combinational function of state, valids and last_grant only.

## Test plan
- Single ADD: r0 op=010, a=2, b=3, resp_ready=1 -> r0_ready at T, alu_sel=010 at T+1, r0_resp_valid at T+2 with data=5, zero=0, neg=0, err=0.
- SUB to negative and zero: r1 op=011 a=1 b=2 -> data=0xFFFF_FFFF_FFFF_FFFF, neg=1; then a=7 b=7 -> data=0, zero=1.
- Contention: r0 and r1 both valid continuously (op=100, 101) after reset -> grants alternate r0, r1, r0, r1; each response on correct port only.
- Illegal op: r0 op=111 -> resp at T+1 with err=1, data=0, zero=1; alu_sel never takes 111; next r1 request still served.
- Backpressure: hold r0_resp_ready=0 for 10 cycles -> resp_valid and data stable, r1_ready stays 0, busy=1; release -> IDLE next cycle, r1 accepted.
- Reset in ISSUE: assert reset one cycle during ISSUE -> no resp_valid, all outputs at reset values, next request after release completes normally with r0 winning first tie.
